// File: rtl/atm_multi_account.sv
`default_nettype none
// ============================================================================
// Module   : atm_multi_account
// Brief    : Multi-account ATM transaction controller with PIN lockout,
//            denomination check, per-account balances and a finite vault.
// Revision : 1.0 - initial release
// ============================================================================
module atm_multi_account #(
  parameter int               NUM_ACCOUNTS  = 4,
  parameter int               ID_W          = 4,
  parameter int               PIN_W         = 16,
  parameter int               AMT_W         = 14,
  parameter int               VAULT_W       = 18,
  parameter logic [PIN_W-1:0] PIN_BASE      = 16'h1234,
  parameter int               INIT_BALANCE  = 3000,
  parameter int               ATM_OUT_LIMIT = 7000,
  parameter int               DENOM         = 20,
  parameter int               VAULT_INIT    = 20000,
  parameter int               MAX_PIN_TRIES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cancel,
  input  logic               next,
  input  logic [ID_W-1:0]    card_id,
  input  logic [PIN_W-1:0]   pin,
  input  logic [AMT_W-1:0]   cash_in,
  output logic               success,
  output logic [AMT_W-1:0]   cash_out,
  output logic [2:0]         state_display,
  output logic [2:0]         err_code,
  output logic               acct_locked,
  output logic [VAULT_W-1:0] vault_level
);

  localparam int IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
  localparam int FC_W  = $clog2(MAX_PIN_TRIES + 1);

  localparam logic [AMT_W-1:0]   c_out_limit  = AMT_W'(ATM_OUT_LIMIT);
  localparam logic [AMT_W-1:0]   c_denom      = AMT_W'(DENOM);
  localparam logic [AMT_W-1:0]   c_init_bal   = AMT_W'(INIT_BALANCE);
  localparam logic [VAULT_W-1:0] c_vault_init = VAULT_W'(VAULT_INIT);
  localparam logic [FC_W-1:0]    c_max_tries  = FC_W'(MAX_PIN_TRIES);

  localparam logic [2:0] c_err_none   = 3'd0;
  localparam logic [2:0] c_err_card   = 3'd1;
  localparam logic [2:0] c_err_locked = 3'd2;
  localparam logic [2:0] c_err_pin    = 3'd3;
  localparam logic [2:0] c_err_amt    = 3'd4;
  localparam logic [2:0] c_err_bal    = 3'd5;
  localparam logic [2:0] c_err_vault  = 3'd6;

  typedef enum logic [2:0] {
    S_SCAN     = 3'd0,
    S_PIN      = 3'd1,
    S_AMT      = 3'd2,
    S_VERIFY   = 3'd3,
    S_DISPENSE = 3'd4,
    S_REJECT   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_nxt_state;
  logic [2:0]          r_err;
  logic [2:0]          w_nxt_err;
  logic [AMT_W-1:0]    r_amt;
  logic [ID_W-1:0]     r_acct;
  logic                r_next_prev;
  logic                r_step;
  logic [VAULT_W-1:0]  r_vault;
  logic [AMT_W-1:0]    r_bal  [NUM_ACCOUNTS];
  logic [FC_W-1:0]     r_fail [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] r_lock;

  logic                w_card_valid;
  logic                w_card_locked;
  logic [IDX_W-1:0]    w_card_idx;
  logic                w_acct_valid;
  logic [IDX_W-1:0]    w_idx;
  logic [PIN_W-1:0]    w_pin_exp;
  logic [FC_W-1:0]     w_fail_inc;
  logic                w_amt_ok;
  logic [VAULT_W-1:0]  w_amt_ext;
  logic                w_bal_short;
  logic                w_vault_short;

  logic w_latch_acct, w_latch_amt, w_clr_amt, w_debit;
  logic w_fail_up, w_fail_clr, w_lock_set;

  assign w_card_valid  = 32'(card_id) < NUM_ACCOUNTS;
  assign w_card_idx    = card_id[IDX_W-1:0];
  assign w_card_locked = w_card_valid && r_lock[w_card_idx];
  assign w_acct_valid  = 32'(r_acct) < NUM_ACCOUNTS;
  assign w_idx         = r_acct[IDX_W-1:0];
  assign w_pin_exp     = PIN_BASE + PIN_W'(r_acct);
  assign w_fail_inc    = r_fail[w_idx] + FC_W'(1);
  assign w_amt_ok      = (cash_in != '0) && (cash_in <= c_out_limit) &&
                         ((cash_in % c_denom) == '0);
  assign w_amt_ext     = VAULT_W'(r_amt);
  assign w_bal_short   = r_amt > r_bal[w_idx];
  assign w_vault_short = w_amt_ext > r_vault;

  // The rising edge of next is captured in r_step and acted upon one clock later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_prev <= 1'b0;
      r_step      <= 1'b0;
    end else begin
      r_next_prev <= next;
      r_step      <= next & ~r_next_prev & ~cancel;
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_err    = r_err;
    w_latch_acct = 1'b0;
    w_latch_amt  = 1'b0;
    w_clr_amt    = 1'b0;
    w_debit      = 1'b0;
    w_fail_up    = 1'b0;
    w_fail_clr   = 1'b0;
    w_lock_set   = 1'b0;
    if (cancel) begin
      w_nxt_state = S_SCAN;
      w_nxt_err   = c_err_none;
      w_clr_amt   = 1'b1;
    end else if (r_step) begin
      w_nxt_err = c_err_none;
      case (r_state)
        S_SCAN: begin
          w_latch_acct = 1'b1;
          if (!w_card_valid) begin
            w_nxt_state = S_REJECT;
            w_nxt_err   = c_err_card;
          end else if (w_card_locked) begin
            w_nxt_state = S_REJECT;
            w_nxt_err   = c_err_locked;
          end else begin
            w_nxt_state = S_PIN;
          end
        end
        S_PIN: begin
          if (pin == w_pin_exp) begin
            w_fail_clr  = 1'b1;
            w_nxt_state = S_AMT;
          end else begin
            w_fail_up = 1'b1;
            if (w_fail_inc == c_max_tries) begin
              w_lock_set  = 1'b1;
              w_nxt_state = S_REJECT;
              w_nxt_err   = c_err_locked;
            end else begin
              w_nxt_err = c_err_pin;
            end
          end
        end
        S_AMT: begin
          if (w_amt_ok) begin
            w_latch_amt = 1'b1;
            w_nxt_state = S_VERIFY;
          end else begin
            w_nxt_err = c_err_amt;
          end
        end
        S_VERIFY: begin
          if (w_bal_short) begin
            w_nxt_state = S_SCAN;
            w_nxt_err   = c_err_bal;
          end else if (w_vault_short) begin
            w_nxt_state = S_SCAN;
            w_nxt_err   = c_err_vault;
          end else begin
            w_debit     = 1'b1;
            w_nxt_state = S_DISPENSE;
          end
        end
        S_DISPENSE: begin
          w_clr_amt   = 1'b1;
          w_nxt_state = S_SCAN;
        end
        S_REJECT: w_nxt_state = S_SCAN;
        default:  w_nxt_state = S_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_SCAN;
      r_err   <= c_err_none;
      r_amt   <= '0;
      r_acct  <= '0;
      r_vault <= c_vault_init;
    end else begin
      r_state <= w_nxt_state;
      r_err   <= w_nxt_err;
      if (w_clr_amt)
        r_amt <= '0;
      else if (w_latch_amt)
        r_amt <= cash_in;
      if (w_latch_acct)
        r_acct <= card_id;
      if (w_debit)
        r_vault <= r_vault - w_amt_ext;
    end
  end

  // Per-account state is only touched for the latched, valid account.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        r_bal[i]  <= c_init_bal;
        r_fail[i] <= '0;
        r_lock[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        if (w_acct_valid && (w_idx == IDX_W'(i))) begin
          if (w_debit)
            r_bal[i] <= r_bal[i] - r_amt;
          if (w_fail_clr)
            r_fail[i] <= '0;
          else if (w_fail_up)
            r_fail[i] <= w_fail_inc;
          if (w_lock_set)
            r_lock[i] <= 1'b1;
        end
      end
    end
  end

  assign success       = (r_state == S_DISPENSE);
  assign cash_out      = (r_state == S_DISPENSE) ? r_amt : '0;
  assign state_display = r_state;
  assign err_code      = r_err;
  assign acct_locked   = w_acct_valid && r_lock[w_idx];
  assign vault_level   = r_vault;

endmodule
`default_nettype wire

// File: tb/tb_atm_multi_account.sv
`default_nettype none
// ============================================================================
// Module   : tb_atm_multi_account
// Brief    : Directed self-checking bench for atm_multi_account.
// Revision : 1.0 - initial release
// ============================================================================
module tb_atm_multi_account;

  logic        clk;
  logic        rst_n;
  logic        cancel;
  logic        next;
  logic [3:0]  card_id;
  logic [15:0] pin;
  logic [13:0] cash_in;

  logic        success,   v_success;
  logic [13:0] cash_out,  v_cash_out;
  logic [2:0]  state_display, v_state_display;
  logic [2:0]  err_code,  v_err_code;
  logic        acct_locked, v_acct_locked;
  logic [17:0] vault_level, v_vault_level;

  int total = 0;
  int bad   = 0;

  atm_multi_account dut (
    .clk(clk), .rst_n(rst_n), .cancel(cancel), .next(next),
    .card_id(card_id), .pin(pin), .cash_in(cash_in),
    .success(success), .cash_out(cash_out), .state_display(state_display),
    .err_code(err_code), .acct_locked(acct_locked), .vault_level(vault_level)
  );

  // Small-vault instance so that the vault shortage path is reachable.
  atm_multi_account #(.VAULT_INIT(2500)) dut_v (
    .clk(clk), .rst_n(rst_n), .cancel(cancel), .next(next),
    .card_id(card_id), .pin(pin), .cash_in(cash_in),
    .success(v_success), .cash_out(v_cash_out), .state_display(v_state_display),
    .err_code(v_err_code), .acct_locked(v_acct_locked), .vault_level(v_vault_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press();
    next = 1'b1;
    @(negedge clk);
    @(negedge clk);
    next = 1'b0;
    @(negedge clk);
  endtask

  task automatic go(input logic [3:0] c, input logic [15:0] p, input logic [13:0] a);
    card_id = c;
    pin     = p;
    cash_in = a;
    press();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Card, PIN, amount and verify steps for one withdrawal.
  task automatic withdraw(input logic [3:0] c, input logic [13:0] a);
    go(c, 16'h1234 + 16'(c), 14'd0);
    go(c, 16'h1234 + 16'(c), 14'd0);
    go(c, 16'h1234 + 16'(c), a);
    go(c, 16'h1234 + 16'(c), a);
  endtask

  initial begin
    rst_n = 1'b0; cancel = 1'b0; next = 1'b0;
    card_id = '0; pin = '0; cash_in = '0;
    #23;
    chk("rst_state",   32'(state_display), 0);
    chk("rst_success", 32'(success), 0);
    chk("rst_cash",    32'(cash_out), 0);
    chk("rst_err",     32'(err_code), 0);
    chk("rst_locked",  32'(acct_locked), 0);
    chk("rst_vault",   32'(vault_level), 20000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Happy path, including the one-cycle step latency.
    card_id = 4'd1; pin = 16'h1235; cash_in = 14'd1000;
    next = 1'b1;
    @(negedge clk);
    chk("lat_early", 32'(state_display), 0);
    @(negedge clk);
    chk("lat_step", 32'(state_display), 1);
    next = 1'b0;
    @(negedge clk);
    go(4'd1, 16'h1235, 14'd1000);
    chk("hp_amt", 32'(state_display), 2);
    go(4'd1, 16'h1235, 14'd1000);
    chk("hp_verify", 32'(state_display), 3);
    go(4'd1, 16'h1235, 14'd1000);
    chk("hp_disp_state", 32'(state_display), 4);
    chk("hp_success",    32'(success), 1);
    chk("hp_cash",       32'(cash_out), 1000);
    chk("hp_vault",      32'(vault_level), 19000);
    chk("hp_err",        32'(err_code), 0);
    go(4'd1, 16'h1235, 14'd1000);
    chk("hp_back",     32'(state_display), 0);
    chk("hp_cash_off", 32'(cash_out), 0);
    // Balance of account 1 is now 2000.
    withdraw(4'd1, 14'd2020);
    chk("bal1_state", 32'(state_display), 0);
    chk("bal1_err",   32'(err_code), 5);

    // Lockout of account 0.
    go(4'd0, 16'h0000, 14'd0);
    chk("lk_pin", 32'(state_display), 1);
    go(4'd0, 16'h0000, 14'd0);
    chk("lk_err1", 32'(err_code), 3);
    chk("lk_st1",  32'(state_display), 1);
    go(4'd0, 16'h0000, 14'd0);
    chk("lk_err2", 32'(err_code), 3);
    go(4'd0, 16'h0000, 14'd0);
    chk("lk_st3",   32'(state_display), 5);
    chk("lk_err3",  32'(err_code), 2);
    chk("lk_flag",  32'(acct_locked), 1);
    go(4'd0, 16'h0000, 14'd0);
    chk("lk_back", 32'(state_display), 0);
    go(4'd0, 16'h1234, 14'd0);
    chk("lk_again_st",  32'(state_display), 5);
    chk("lk_again_err", 32'(err_code), 2);
    go(4'd0, 16'h1234, 14'd0);

    // Card 2 still works; amount checks.
    go(4'd2, 16'h1236, 14'd0);
    chk("c2_pin",    32'(state_display), 1);
    chk("c2_unlock", 32'(acct_locked), 0);
    go(4'd2, 16'h1236, 14'd0);
    chk("c2_amt", 32'(state_display), 2);
    go(4'd2, 16'h1236, 14'd0);
    chk("amt0_st", 32'(state_display), 2);
    chk("amt0_err", 32'(err_code), 4);
    go(4'd2, 16'h1236, 14'd7020);
    chk("amt7020_st", 32'(state_display), 2);
    chk("amt7020_err", 32'(err_code), 4);
    go(4'd2, 16'h1236, 14'd1010);
    chk("amt1010_st", 32'(state_display), 2);
    chk("amt1010_err", 32'(err_code), 4);
    go(4'd2, 16'h1236, 14'd7000);
    chk("amt7000_st", 32'(state_display), 3);
    chk("amt7000_err", 32'(err_code), 0);
    go(4'd2, 16'h1236, 14'd7000);
    chk("amt_bal_st", 32'(state_display), 0);
    chk("amt_bal_err", 32'(err_code), 5);

    // Invalid card.
    go(4'd9, 16'h0000, 14'd0);
    chk("inv_st",  32'(state_display), 5);
    chk("inv_err", 32'(err_code), 1);
    go(4'd9, 16'h0000, 14'd0);
    chk("inv_back", 32'(state_display), 0);

    // next held high for 10 cycles gives a single step.
    card_id = 4'd3; pin = 16'h1237; cash_in = 14'd100;
    next = 1'b1;
    repeat (10) @(negedge clk);
    next = 1'b0;
    @(negedge clk);
    chk("hold_one", 32'(state_display), 1);
    go(4'd3, 16'h1237, 14'd100);
    go(4'd3, 16'h1237, 14'd100);
    chk("cx_verify", 32'(state_display), 3);
    // cancel together with a next rise in S_VERIFY.
    cancel = 1'b1; next = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    @(negedge clk);
    next = 1'b0;
    @(negedge clk);
    chk("cx_state", 32'(state_display), 0);
    chk("cx_err",   32'(err_code), 0);
    chk("cx_vault", 32'(vault_level), 19000);
    chk("cx_cash",  32'(cash_out), 0);

    // Vault shortage on the small-vault instance; cancel in S_DISPENSE keeps the debit.
    do_reset();
    withdraw(4'd0, 14'd3000);
    chk("vs_main_st",  32'(state_display), 4);
    chk("vs_main_vlt", 32'(vault_level), 17000);
    chk("vs_v_st",     32'(v_state_display), 0);
    chk("vs_v_err",    32'(v_err_code), 6);
    chk("vs_v_vlt",    32'(v_vault_level), 2500);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    @(negedge clk);
    chk("cd_state", 32'(state_display), 0);
    chk("cd_vault", 32'(vault_level), 17000);
    chk("cd_succ",  32'(success), 0);

    // Balance depletion and vault drain.
    do_reset();
    withdraw(4'd2, 14'd3000);
    chk("dp2_st",  32'(state_display), 4);
    chk("dp2_vlt", 32'(vault_level), 17000);
    go(4'd2, 16'h1236, 14'd3000);
    withdraw(4'd2, 14'd20);
    chk("dp2b_st",  32'(state_display), 0);
    chk("dp2b_err", 32'(err_code), 5);
    withdraw(4'd0, 14'd3000);
    go(4'd0, 16'h1234, 14'd3000);
    withdraw(4'd1, 14'd3000);
    go(4'd1, 16'h1235, 14'd3000);
    withdraw(4'd3, 14'd3000);
    chk("dr_st",   32'(state_display), 4);
    chk("dr_vlt",  32'(vault_level), 8000);
    chk("dr_cash", 32'(cash_out), 3000);

    // Asynchronous reset while in S_DISPENSE.
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state",  32'(state_display), 0);
    chk("ar_succ",   32'(success), 0);
    chk("ar_cash",   32'(cash_out), 0);
    chk("ar_err",    32'(err_code), 0);
    chk("ar_locked", 32'(acct_locked), 0);
    chk("ar_vault",  32'(vault_level), 20000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
